// File: rtl/reg_snapshot_reader_pkg.sv
// Shared constants for the register snapshot reader.
// Holds the FSM encoding, default width and counter sizing.
package reg_snapshot_reader_pkg;

  localparam int DEF_WIDTH = 16;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // Bit counter width: ceil(log2(w)), never below 1.
  function automatic int cnt_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/reg_snapshot_reader_piso.sv
// Parallel-in serial-out shifter with bit counter.
// Ports: clk_i, rst_i, load_i/data_i, shift_i -> msb_o, last_o.
module piso_shifter
  import reg_snapshot_reader_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CW    = cnt_w(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             shift_i,
  output logic             msb_o,
  output logic             last_o
);

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (load_i) begin
      sr_d  = data_i;
      cnt_d = '0;
    end else if (shift_i) begin
      sr_d = {sr_q[WIDTH-2:0], 1'b0};
      // Saturate on the final bit so the counter never wraps.
      if (cnt_q != LAST) cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  assign msb_o  = sr_q[WIDTH-1];
  assign last_o = (cnt_q == LAST);

endmodule

// File: rtl/reg_snapshot_reader.sv
// Captures a register snapshot and streams it MSB first plus even parity.
// Ports: CLK, RST, start, snap_in, sout/sout_valid/sout_ready, busy, done, start_drop.
module reg_snapshot_reader
  import reg_snapshot_reader_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [WIDTH-1:0] snap_in,
  output logic             sout,
  output logic             sout_valid,
  input  logic             sout_ready,
  output logic             busy,
  output logic             done,
  output logic             start_drop
);

  logic [1:0] state_q, state_d;
  logic       par_q, par_d;
  logic       in_idle, in_shift, in_par, in_done;
  logic       load, shift, msb, last;

  assign in_idle  = (state_q == ST_IDLE);
  assign in_shift = (state_q == ST_SHIFT);
  assign in_par   = (state_q == ST_PARITY);
  assign in_done  = (state_q == ST_DONE);

  assign load  = in_idle & start;
  assign shift = in_shift & sout_ready;

  piso_shifter #(
    .WIDTH (WIDTH)
  ) u_piso (
    .clk_i   (CLK),
    .rst_i   (RST),
    .load_i  (load),
    .data_i  (snap_in),
    .shift_i (shift),
    .msb_o   (msb),
    .last_o  (last)
  );

  always_comb begin
    state_d = state_q;
    par_d   = par_q;
    unique case (1'b1)
      in_idle: begin
        if (start) begin
          par_d   = ^snap_in;
          state_d = ST_SHIFT;
        end
      end
      in_shift: begin
        if (sout_ready && last) state_d = ST_PARITY;
      end
      in_par: begin
        if (sout_ready) state_d = ST_DONE;
      end
      in_done: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      par_q   <= par_d;
    end
  end

  assign sout_valid = in_shift | in_par;
  assign sout       = (in_shift & msb) | (in_par & par_q);
  assign busy       = ~in_idle;
  assign done       = in_done;
  // Requests seen while busy (DONE included) are dropped, not queued.
  assign start_drop = start & ~in_idle & ~RST;

endmodule

// File: doc/reg_snapshot_reader.md
REG_SNAPSHOT_READER -- requirements
Module: reg_snapshot_reader

Interface
REQ-001 Parameter: WIDTH, default 16, sets the bit count of the captured register snapshot; legal range 2..64.
REQ-002 Port: CLK  input  1  sole clock; all state updates on the rising edge.
REQ-003 Port: RST  input  1  reset, synchronous and active-high.
REQ-004 Port: start  input  1  request to capture snap_in and begin readout.
REQ-005 Port: snap_in  input  WIDTH  parallel register values to be read out.
REQ-006 Port: sout  output  1  serial data bit, MSB first, followed by one even-parity bit.
REQ-007 Port: sout_valid  output  1  sout holds a bit offered to the consumer.
REQ-008 Port: sout_ready  input  1  consumer accepts the offered bit.
REQ-009 Port: busy  output  1  high from the capture cycle until DONE is exited.
REQ-010 Port: done  output  1  single-cycle pulse after the parity bit is accepted.
REQ-011 Port: start_drop  output  1  single-cycle pulse when start arrives while busy.

Function
REQ-012 The FSM SHALL have states IDLE, SHIFT, PARITY and DONE.
REQ-013 In IDLE with start=1, the block SHALL load snap_in into a shift register, compute even parity (XOR-reduce) of snap_in, clear the bit counter and enter SHIFT on the next edge.
REQ-014 In SHIFT, sout_valid SHALL be 1 and sout SHALL equal the shift register MSB.
REQ-015 A bit transfer SHALL occur only in a cycle with sout_valid=1 and sout_ready=1; on transfer the register shifts left by one and the counter increments.
REQ-016 While sout_ready=0, sout and sout_valid SHALL hold stable; the block SHALL NOT drop or advance a bit.
REQ-017 The transfer of bit index WIDTH-1 (counter=WIDTH-1) SHALL move the FSM to PARITY.
REQ-018 In PARITY, sout_valid SHALL be 1 and sout SHALL equal the stored parity bit; on transfer the FSM SHALL enter DONE.
REQ-019 In DONE, done SHALL be 1 for exactly one cycle, sout_valid SHALL be 0, and the FSM SHALL return to IDLE on the next edge.
REQ-020 busy SHALL be 1 in SHIFT, PARITY and DONE and 0 in IDLE.
REQ-021 start while busy=1 SHALL be ignored and SHALL pulse start_drop for that cycle; snapshot contents SHALL NOT change.
REQ-022 start in the same cycle the FSM is in DONE SHALL be dropped (start_drop=1); a new capture requires start in IDLE.
REQ-023 Minimum latency, start to done, with sout_ready tied high: WIDTH+2 cycles (capture edge, WIDTH data transfers, parity transfer; done asserted in the following cycle).
REQ-024 The bit counter SHALL be ceil(log2(WIDTH)) bits wide and SHALL NOT wrap in normal operation.
REQ-025 In IDLE and DONE, sout SHALL be 0.

Reset
REQ-026 RST=1 at a clock edge SHALL force IDLE and clear the shift register, counter and parity bit, and SHALL set sout, sout_valid, busy, done and start_drop to 0.
REQ-027 RST asserted mid-readout SHALL abort the transfer without a done pulse; start is ignored while RST=1.

Structure
REQ-028 A shared package SHALL hold the FSM state encoding (2-bit: IDLE=0, SHIFT=1, PARITY=2, DONE=3) and the default WIDTH constant.
REQ-029 The piso shift register with its counter SHALL be one sub-module, piso_shifter; the FSM and parity logic SHALL stay at top level.

Verification
REQ-030 WIDTH=16, snap_in=16'hA5C3, start pulse, sout_ready=1 -> bits 1010_0101_1100_0011 then parity 0; done pulses 18 cycles after start.
REQ-031 snap_in=16'h0001, sout_ready toggling 1/0 every cycle -> same bit sequence with each bit held while ready=0; parity 1; no lost or duplicated bits.
REQ-032 start re-asserted during SHIFT with snap_in=16'hFFFF -> start_drop=1 that cycle; output continues the original snapshot.
REQ-033 RST=1 after 5 accepted bits -> next cycle busy=0, sout_valid=0, no done; a later start with 16'h8000 reads out cleanly from bit 15.
REQ-034 start asserted in the DONE cycle -> start_drop=1, FSM returns to IDLE; start one cycle later is accepted.
REQ-035 WIDTH=2, snap_in=2'b11 -> sout 1,1, parity 0; done 4 cycles after start.
